// File: rtl/uart_tx.sv
// uart_tx: buffered 8-bit UART transmitter.
//
// Ports:
//   clk       system clock; all logic on its rising edge
//   reset     asynchronous, active-low reset
//   tx_data   byte to transmit, taken when tx_valid && tx_ready
//   tx_valid  producer offers tx_data this cycle
//   tx_ready  transmit FIFO has room for a byte
//   tx        serial line, idle high, driven from a flop
//   tx_busy   a frame is on the line or the FIFO still holds data
//
// Configuration macro: UART_TX_PARITY_EN
//   defined   -> an even parity bit follows the data bits (11-bit frame)
//   undefined -> 8N1 (10-bit frame)
//
// state  | meaning
// IDLE   | line high, waiting for the FIFO to hold a byte
// START  | start bit (low) for one bit period
// DATA   | eight data bits, LSB first
// PARITY | even parity bit (parity build only)
// STOP   | stop bit (high); chains straight into START if more data is queued
module uart_tx #(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUDRATE   = 300000,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx,
   output logic       tx_busy
);

   localparam int CYCLES = CLK_FREQ / (BAUDRATE * 16);
   localparam int PW     = (CYCLES > 1) ? $clog2(CYCLES) : 1;
   localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   localparam logic [PW-1:0] PRESC_LOAD = PW'(CYCLES - 1);
   localparam logic [AW:0]   DEPTH_C    = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_TX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   state_t          state;
   logic [PW-1:0]   presc;
   logic [3:0]      tick_cnt;
   logic [2:0]      bit_idx;
   logic [7:0]      shreg;
`ifdef UART_TX_PARITY_EN
   logic            par_bit;
`endif

   logic [7:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [AW:0]     count;

   logic            bit_end;
   logic            wr;
   logic            pop;
   logic [7:0]      head;

   // Both timers are down-counters; a bit period ends on the prescaler's
   // terminal count while the tick counter is also at zero.
   assign bit_end  = (presc == '0) && (tick_cnt == '0);
   assign tx_ready = (count < DEPTH_C);
   assign wr       = tx_valid && tx_ready;
   assign pop      = (count != '0) &&
                     ((state == S_IDLE) || ((state == S_STOP) && bit_end));
   assign head     = mem[rd_ptr];
   assign tx_busy  = (state != S_IDLE) || (count != '0);

   always_ff @(posedge clk) begin
      if (wr) mem[wr_ptr] <= tx_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr)  wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({wr, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         tx       <= 1'b1;
         presc    <= '0;
         tick_cnt <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
`ifdef UART_TX_PARITY_EN
         par_bit  <= 1'b0;
`endif
      end else begin
         // Free-running bit timer while a frame is active; the tick counter
         // wraps from 0 back to 15 on the edge that closes a bit period.
         if (state != S_IDLE) begin
            if (presc == '0) begin
               presc    <= PRESC_LOAD;
               tick_cnt <= tick_cnt - 1'b1;
            end else begin
               presc <= presc - 1'b1;
            end
         end

         case (state)
            S_IDLE: begin
               tx <= 1'b1;
               if (pop) begin
                  shreg    <= head;
`ifdef UART_TX_PARITY_EN
                  par_bit  <= ^head;
`endif
                  tx       <= 1'b0;
                  presc    <= PRESC_LOAD;
                  tick_cnt <= 4'hF;
                  state    <= S_START;
               end
            end
            S_START: begin
               if (bit_end) begin
                  tx      <= shreg[0];
                  shreg   <= shreg >> 1;
                  bit_idx <= '0;
                  state   <= S_DATA;
               end
            end
            S_DATA: begin
               if (bit_end) begin
                  if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     tx    <= par_bit;
                     state <= S_PARITY;
`else
                     tx    <= 1'b1;
                     state <= S_STOP;
`endif
                  end else begin
                     tx      <= shreg[0];
                     shreg   <= shreg >> 1;
                     bit_idx <= bit_idx + 1'b1;
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
               if (bit_end) begin
                  tx    <= 1'b1;
                  state <= S_STOP;
               end
            end
`endif
            S_STOP: begin
               if (bit_end) begin
                  if (pop) begin
                     shreg    <= head;
`ifdef UART_TX_PARITY_EN
                     par_bit  <= ^head;
`endif
                     tx       <= 1'b0;
                     presc    <= PRESC_LOAD;
                     tick_cnt <= 4'hF;
                     state    <= S_START;
                  end else begin
                     state <= S_IDLE;
                  end
               end
            end
            default: begin
               tx    <= 1'b1;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx at default parameters
// (160 clocks per bit). Accepted bytes are queued with a flag saying whether
// their frame must start with no idle gap; a line monitor decodes every frame
// and checks it against the queue head.
module tb_uart_tx;

   localparam int BIT_CLKS = 160;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FRAME = NBITS * BIT_CLKS;

   typedef struct {
      logic [7:0] data;
      bit         b2b;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       tx;
   logic       tx_busy;

   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;
   bit   mon_en = 1'b1;
   exp_t sb[$];

   uart_tx dut (
      .clk      (clk),
      .reset    (rst_n),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .tx       (tx),
      .tx_busy  (tx_busy)
   );

   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input logic [7:0] d, input bit b2b);
      exp_t e;
      e.data = d;
      e.b2b  = b2b;
      sb.push_back(e);
   endtask

   task automatic wait_idle(input int limit);
      int k = 0;
      while (tx_busy && k < limit) begin
         @(negedge clk);
         k++;
      end
      repeat (4) @(negedge clk);
      check("idle_timeout", {31'd0, tx_busy}, 32'd0);
   endtask

   // line monitor / scoreboard checker
   initial begin : monitor
      logic [10:0] bits;
      bit          stable;
      bit          aborted;
      int          start_cyc;
      int          prev_end;
      exp_t        e;
      prev_end = -10;
      forever begin
         @(negedge clk);
         if (mon_en && tx === 1'b0) begin
            start_cyc = cyc;
            stable    = 1'b1;
            aborted   = 1'b0;
            bits      = '0;
            for (int k = 0; k < NBITS && !aborted; k++) begin
               for (int j = 0; j < BIT_CLKS; j++) begin
                  if (k != 0 || j != 0) @(negedge clk);
                  if (!mon_en) aborted = 1'b1;
                  else if (j == 0) bits[k] = tx;
                  else if (tx !== bits[k]) stable = 1'b0;
               end
            end
            if (!aborted) begin
               if (sb.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL unexpected_frame: got frame bits %b expected no frame", bits);
               end else begin
                  e = sb.pop_front();
                  check("start_bit", {31'd0, bits[0]}, 32'd0);
                  check("data_byte", {24'd0, bits[8:1]}, {24'd0, e.data});
`ifdef UART_TX_PARITY_EN
                  check("parity_bit", {31'd0, bits[9]}, {31'd0, ^e.data});
`endif
                  check("stop_bit", {31'd0, bits[NBITS-1]}, 32'd1);
                  check("bit_timing", {31'd0, stable}, 32'd1);
                  if (e.b2b) check("no_gap", start_cyc, prev_end + 1);
               end
               prev_end = cyc;
            end
         end
      end
   end

   initial begin : watchdog
      #1600000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int   k;
      int   t0;
      int   lows;
      logic [7:0] six [6];
      bit         rdy_exp [6];
      six     = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      rdy_exp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

      tx_valid = 1'b0;
      tx_data  = 8'h00;
      rst_n    = 1'b1;

      // asynchronous reset before any clock edge
      #2 rst_n = 1'b0;
      #1;
      check("reset_tx", {31'd0, tx}, 32'd1);
      check("reset_ready", {31'd0, tx_ready}, 32'd1);
      check("reset_busy", {31'd0, tx_busy}, 32'd0);
      repeat (3) @(negedge clk);

      // single 0xA5, first edge after release, latency and busy duration
      rst_n    = 1'b1;
      tx_valid = 1'b1;
      tx_data  = 8'hA5;
      check("ready_after_reset", {31'd0, tx_ready}, 32'd1);
      @(posedge clk);
      push(8'hA5, 1'b0);
      @(negedge clk);
      tx_valid = 1'b0;
      check("latency_e0_tx", {31'd0, tx}, 32'd1);
      check("busy_on_write", {31'd0, tx_busy}, 32'd1);
      @(negedge clk);
      check("latency_e1_tx", {31'd0, tx}, 32'd0);
      k = 0;
      while (tx_busy && k < 4 * FRAME) begin
         @(negedge clk);
         k++;
      end
      check("busy_drop_cycles", k, FRAME);
      repeat (10) @(negedge clk);

      // single 0x07 (odd number of ones)
      tx_valid = 1'b1;
      tx_data  = 8'h07;
      @(posedge clk);
      push(8'h07, 1'b0);
      @(negedge clk);
      tx_valid = 1'b0;
      wait_idle(3 * FRAME);

      // six bytes on consecutive cycles; sixth held until ready returns
      for (int i = 0; i < 6; i++) begin
         tx_valid = 1'b1;
         tx_data  = six[i];
         check("burst_ready", {31'd0, tx_ready}, {31'd0, rdy_exp[i]});
         if (i == 5) break;
         @(posedge clk);
         push(six[i], i != 0);
         @(negedge clk);
         if (i == 1) t0 = cyc;
      end
      k = 0;
      while (!tx_ready && k < 2 * FRAME) begin
         @(negedge clk);
         k++;
      end
      check("ready_return_cycle", cyc - t0, FRAME);
      @(posedge clk);
      push(8'h66, 1'b1);
      @(negedge clk);
      tx_valid = 1'b0;
      wait_idle(8 * FRAME);

      // write coinciding with the end-of-stop pop while one byte is queued
      tx_valid = 1'b1;
      tx_data  = 8'h81;
      @(posedge clk);
      push(8'h81, 1'b0);
      @(negedge clk);
      tx_valid = 1'b0;
      @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = 8'h42;
      @(posedge clk);
      push(8'h42, 1'b1);
      @(negedge clk);
      tx_valid = 1'b0;
      repeat (FRAME - 2) @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = 8'h5A;
      check("coincide_ready", {31'd0, tx_ready}, 32'd1);
      @(posedge clk);
      push(8'h5A, 1'b1);
      @(negedge clk);
      tx_valid = 1'b0;
      check("coincide_next_start", {31'd0, tx}, 32'd0);
      wait_idle(4 * FRAME);

      // reset during DATA of 0x3C with two bytes buffered
      mon_en   = 1'b0;
      tx_valid = 1'b1;
      tx_data  = 8'h3C;
      @(posedge clk);
      @(negedge clk);
      tx_data = 8'h99;
      @(posedge clk);
      @(negedge clk);
      tx_data = 8'hAA;
      @(posedge clk);
      @(negedge clk);
      tx_valid = 1'b0;
      repeat (BIT_CLKS + 79) @(negedge clk);
      check("pre_reset_data_bit0", {31'd0, tx}, 32'd0);
      check("pre_reset_busy", {31'd0, tx_busy}, 32'd1);
      #3 rst_n = 1'b0;
      #1;
      check("midframe_reset_tx", {31'd0, tx}, 32'd1);
      check("midframe_reset_ready", {31'd0, tx_ready}, 32'd1);
      check("midframe_reset_busy", {31'd0, tx_busy}, 32'd0);
      repeat (3) @(negedge clk);
      rst_n  = 1'b1;
      mon_en = 1'b1;
      lows   = 0;
      for (int i = 0; i < 2 * FRAME; i++) begin
         @(negedge clk);
         if (tx !== 1'b1 || tx_busy !== 1'b0) lows++;
      end
      check("quiet_after_reset", lows, 0);

      check("scoreboard_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLK_FREQ, default 50000000: system clock frequency in Hz.
REQ-002 Parameter BAUDRATE, default 300000: line bit rate in bit/s.
REQ-003 Parameter FIFO_DEPTH, default 4: transmit buffer depth in bytes; power of two, minimum 2.
REQ-004 Port clk  input  1: single clock; all logic is on its rising edge.
REQ-005 Port reset  input  1: asynchronous, active-low reset.
REQ-006 Port tx_data  input  8: byte to transmit; sampled when tx_valid and tx_ready are both high.
REQ-007 Port tx_valid  input  1: producer offers tx_data this cycle.
REQ-008 Port tx_ready  output  1: buffer can accept a byte this cycle.
REQ-009 Port tx  output  1: serial line, idle high; driven directly from a register.
REQ-010 Port tx_busy  output  1: high while a frame is on the line or the buffer holds data.

Function
REQ-011 Prescaler emits one tick every CYCLES = CLK_FREQ/(BAUDRATE*16) clocks, integer division (10 at defaults); one bit period is 16 ticks (160 clocks at defaults).
REQ-012 Prescaler and tick counter restart on entry to START, so every bit lasts exactly 16*CYCLES clocks.
REQ-013 Handshake: a byte is written to the FIFO on every edge where tx_valid and tx_ready are both high; tx_data is ignored on all other edges.
REQ-014 tx_ready = (FIFO count < FIFO_DEPTH); combinational from registered count; independent of tx_valid.
REQ-015 FSM states: IDLE, START, DATA, PARITY (present only with the macro), STOP.
REQ-016 IDLE: tx=1; when the FIFO is non-empty, pop the head into the shift register, drive tx=0, and enter START on the same edge.
REQ-017 Latency: a byte written into an empty FIFO in IDLE at edge E0 puts tx low at edge E1.
REQ-018 START: hold tx=0 for one bit period, then go to DATA with tx = bit 0.
REQ-019 DATA: shift out 8 bits LSB first, one bit period each, using a 3-bit index that counts 0..7; after bit 7 go to PARITY or STOP.
REQ-020 STOP: hold tx=1 for one bit period; at the end, if the FIFO is non-empty, pop and go directly to START with no idle gap; otherwise go to IDLE.
REQ-021 If a write and a pop occur on the same edge, the count is unchanged and both succeed; a write to a full FIFO cannot occur because tx_ready is low.
REQ-022 FIFO pointers wrap modulo FIFO_DEPTH; the count uses log2(FIFO_DEPTH)+1 bits.
REQ-023 tx_busy = (state != IDLE) or (count != 0).
REQ-024 tx_valid held high while tx_ready is low does not stall or corrupt the frame in flight.

Reset
REQ-025 Asserting reset immediately forces tx=1, state=IDLE, FIFO count=0, pointers=0, prescaler=0, and tick and bit counters=0, with no dependence on clk.
REQ-026 During reset, tx_ready=1 and tx_busy=0; a frame in progress is abandoned and buffered bytes are discarded.
REQ-027 First write is accepted on the first rising edge after reset deasserts.

Configuration
REQ-028 Macro UART_TX_PARITY_EN defined: PARITY state is compiled in; after DATA, tx = XOR of the 8 data bits (even parity) for one bit period; the frame is 11 bits.
REQ-029 Macro UART_TX_PARITY_EN undefined: no parity logic; DATA goes to STOP; the frame is 10 bits (8N1).

Verification
REQ-030 Single byte 0xA5 written in idle -> tx low one cycle later, then bits 0,1,0,1,0,0,1,0,1,1 with 160 clocks each; tx_busy then drops.
REQ-031 Parity build, 0xA5 then 0x07 -> parity bits 0 and 1 respectively, each inserted before the stop bit; frame length 1760 clocks.
REQ-032 Six bytes offered on consecutive cycles from idle (depth 4) -> five accepted, tx_ready low on the sixth; ready returns when the second frame starts.
REQ-033 Five buffered bytes -> five frames back to back, with the stop bit exactly 160 clocks and no gap before the next start bit.
REQ-034 Reset asserted mid-DATA of 0x3C with two bytes buffered -> tx=1 asynchronously, tx_ready=1, tx_busy=0; no output after release.
REQ-035 Write and end-of-STOP pop on the same edge with count 1 -> count stays 1, and both bytes are transmitted in order.
